seletor_coord_param: RTL and testbench

- Parametrised, registered successor of the fixed 3-bit coordinate-to-demux selector.
- Accepts a (column, row) coordinate on a valid/ready handshake and maps it to a tile channel of a COLS x ROWS matrix split into TILE_W x TILE_H tiles.
- Presents the channel select with an output handshake, then strobes a demux enable for a programmable dwell time.
- Sits between the input/cursor logic and the matrix demultiplexer tree.

---
 rtl/seletor_coord_param_if.sv | 35 +++
 rtl/seletor_coord_param.sv | 143 ++++++++++++++
 tb/tb_seletor_coord_param.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seletor_coord_param_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module  : seletor_coord_param_if
// Brief   : Coordinate-in / channel-select-out handshake bundle for the
//           parametrised tile selector.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
interface seletor_coord_param_if #(
  parameter int COORD_W = 3,
  parameter int SEL_W   = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] mdc;
  logic [COORD_W-1:0] mdl;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   dmx_sel;
  logic               out_err;
  logic               dmx_en;
  logic               busy;

  // Selector side
  modport slave (
    input  in_valid, mdc, mdl, out_ready,
    output in_ready, out_valid, dmx_sel, out_err, dmx_en, busy
  );

  // Cursor logic / demux tree side
  modport master (
    output in_valid, mdc, mdl, out_ready,
    input  in_ready, out_valid, dmx_sel, out_err, dmx_en, busy
  );
endinterface
`default_nettype wire

// File: rtl/seletor_coord_param.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module  : seletor_coord_param
// Brief   : Registered (column,row) -> tile channel selector. Accepts one
//           coordinate, decodes it in one cycle, presents the channel with a
//           handshake, then strobes the demux enable for HOLD_CYC cycles.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
module seletor_coord_param #(
  parameter int COORD_W  = 3,
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int TILE_W   = 4,
  parameter int TILE_H   = 4,
  parameter int SEL_W    = 2,
  parameter int HOLD_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seletor_coord_param_if.slave bus
);

  localparam int TILES_X = COLS / TILE_W;
  localparam int CNT_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    PRESENT = 2'd2,
    DWELL   = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [COORD_W-1:0] col_lat;
  logic [COORD_W-1:0] row_lat;
  logic [SEL_W-1:0]   sel_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   dwell_cnt;

  logic               in_ready_c;
  logic               out_valid_c;
  logic               dmx_en_c;
  logic               busy_c;

  logic [31:0]        col_wide;
  logic [31:0]        row_wide;
  logic [31:0]        sel_full;
  logic               coord_err;

  // Decode arithmetic is done at 32 bits so COLS/ROWS equal to 2^COORD_W
  // compare correctly; the result is truncated to SEL_W when registered.
  always_comb begin
    col_wide  = 32'(col_lat);
    row_wide  = 32'(row_lat);
    coord_err = (col_wide >= 32'(COLS)) || (row_wide >= 32'(ROWS));
    sel_full  = (row_wide / 32'(TILE_H)) * 32'(TILES_X)
              + (col_wide / 32'(TILE_W));
  end

  // Upper bits of the wide channel index are intentionally discarded.
  generate
    if (SEL_W < 32) begin : g_sel_trunc
      logic unused_sel_bits;
      assign unused_sel_bits = ^sel_full[31:SEL_W];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake/strobe outputs, all decoded from the state.
  always_comb begin
    next_state  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    dmx_en_c    = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.in_valid) next_state = DECODE;
      end
      DECODE: next_state = PRESENT;
      PRESENT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) next_state = err_reg ? IDLE : DWELL;
      end
      DWELL: begin
        dmx_en_c = 1'b1;
        if (dwell_cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the coordinate on acceptance; in_valid outside IDLE is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_lat <= '0;
      row_lat <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      col_lat <= bus.mdc;
      row_lat <= bus.mdl;
    end
  end

  // Register the decoded channel; it is held until the next DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg <= '0;
      err_reg <= 1'b0;
    end else if (state == DECODE) begin
      err_reg <= coord_err;
      sel_reg <= coord_err ? '0 : sel_full[SEL_W-1:0];
    end
  end

  // Dwell counter: loaded on a good handshake, counts down to zero in DWELL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
    end else if (state == PRESENT && bus.out_ready && !err_reg) begin
      dwell_cnt <= CNT_LOAD;
    end else if (state == DWELL && dwell_cnt != '0) begin
      dwell_cnt <= dwell_cnt - 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.dmx_en    = dmx_en_c;
  assign bus.busy      = busy_c;
  assign bus.dmx_sel   = sel_reg;
  assign bus.out_err   = err_reg;

endmodule
`default_nettype wire

// File: tb/tb_seletor_coord_param.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module  : tb_seletor_coord_param
// Brief   : Self-checking bench for seletor_coord_param. Instance 0 uses the
//           default 8x8 / 4x4 / hold 4 configuration, instance 1 uses a
//           6x6 / 3x3 / hold 1 configuration.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
module tb_seletor_coord_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  seletor_coord_param_if #(.COORD_W(3), .SEL_W(2)) b0 ();
  seletor_coord_param_if #(.COORD_W(3), .SEL_W(2)) b1 ();

  seletor_coord_param #(
    .COORD_W(3), .COLS(8), .ROWS(8), .TILE_W(4), .TILE_H(4),
    .SEL_W(2), .HOLD_CYC(4)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  seletor_coord_param #(
    .COORD_W(3), .COLS(6), .ROWS(6), .TILE_W(3), .TILE_H(3),
    .SEL_W(2), .HOLD_CYC(1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // Per-instance drive/observe arrays so tasks can select the instance.
  logic       iv   [2];
  logic [2:0] c_in [2];
  logic [2:0] r_in [2];
  logic       ordy [2];
  logic       irdy [2];
  logic       ov   [2];
  logic [1:0] sel  [2];
  logic       err  [2];
  logic       en   [2];
  logic       bsy  [2];

  assign b0.in_valid = iv[0];   assign b1.in_valid = iv[1];
  assign b0.mdc = c_in[0];      assign b1.mdc = c_in[1];
  assign b0.mdl = r_in[0];      assign b1.mdl = r_in[1];
  assign b0.out_ready = ordy[0]; assign b1.out_ready = ordy[1];
  assign irdy[0] = b0.in_ready;  assign irdy[1] = b1.in_ready;
  assign ov[0]   = b0.out_valid; assign ov[1]   = b1.out_valid;
  assign sel[0]  = b0.dmx_sel;   assign sel[1]  = b1.dmx_sel;
  assign err[0]  = b0.out_err;   assign err[1]  = b1.out_err;
  assign en[0]   = b0.dmx_en;    assign en[1]   = b1.dmx_en;
  assign bsy[0]  = b0.busy;      assign bsy[1]  = b1.busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: instance 0 is the quadrant map (bit1 row half, bit0 column
  // half); instance 1 is a 2x2 grid of 3x3 tiles on a 6x6 matrix.
  function automatic void model(input int w, input int c, input int r,
                                output logic e, output logic [1:0] s);
    if (w == 0) begin
      e = 1'b0;
      s = {r >= 4, c >= 4};
    end else begin
      e = (c >= 6) || (r >= 6);
      s = e ? 2'd0 : 2'((r / 3) * 2 + (c / 3));
    end
  endfunction

  function automatic int hold_of(input int w);
    return (w == 0) ? 4 : 1;
  endfunction

  // One full transaction with 'stall' cycles of out_ready backpressure.
  task automatic txn(input int w, input int c, input int r, input int stall);
    logic       e;
    logic [1:0] s;
    int         cnt;
    model(w, c, r, e, s);
    cnt = 0;
    while (!irdy[w] && cnt < 50) begin @(posedge clk); #1; cnt++; end
    n_chk++;
    if (irdy[w] !== 1'b1) begin
      n_fail++; $display("FAIL ready_timeout[%0d]: in_ready=%b required 1", w, irdy[w]);
    end
    c_in[w] = 3'(c); r_in[w] = 3'(r); iv[w] = 1'b1; ordy[w] = (stall == 0);
    @(posedge clk); #1;
    iv[w] = 1'b0;
    n_chk++;
    if (ov[w] !== 1'b0 || bsy[w] !== 1'b1) begin
      n_fail++; $display("FAIL decode_cycle[%0d]: out_valid=%b busy=%b required 0/1", w, ov[w], bsy[w]);
    end
    @(posedge clk); #1;
    n_chk++;
    if (ov[w] !== 1'b1 || sel[w] !== s || err[w] !== e) begin
      n_fail++;
      $display("FAIL present[%0d] (%0d,%0d): valid=%b sel=%0d err=%b required 1/%0d/%b",
               w, c, r, ov[w], sel[w], err[w], s, e);
    end
    for (int i = 0; i < stall; i++) begin
      iv[w] = 1'($urandom_range(0, 1));
      c_in[w] = 3'($urandom_range(0, 7));
      r_in[w] = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      n_chk++;
      if (ov[w] !== 1'b1 || sel[w] !== s || err[w] !== e || en[w] !== 1'b0 || irdy[w] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d] cyc %0d: valid=%b sel=%0d err=%b en=%b in_ready=%b required 1/%0d/%b/0/0",
                 w, i, ov[w], sel[w], err[w], en[w], irdy[w], s, e);
      end
    end
    iv[w] = 1'b0;
    ordy[w] = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (ov[w] !== 1'b0) begin
      n_fail++; $display("FAIL valid_drop[%0d]: out_valid=%b required 0", w, ov[w]);
    end
    cnt = 0;
    while (en[w] === 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (cnt != (e ? 0 : hold_of(w))) begin
      n_fail++; $display("FAIL dwell_len[%0d]: dmx_en cycles=%0d required %0d", w, cnt, e ? 0 : hold_of(w));
    end
    n_chk++;
    if (irdy[w] !== 1'b1 || sel[w] !== s) begin
      n_fail++; $display("FAIL after_dwell[%0d]: in_ready=%b sel=%0d required 1/%0d", w, irdy[w], sel[w], s);
    end
    ordy[w] = 1'b0;
  endtask

  task automatic test_reset;
    for (int w = 0; w < 2; w++) begin
      n_chk++;
      if (irdy[w] !== 1'b1 || ov[w] !== 1'b0 || sel[w] !== 2'd0 || err[w] !== 1'b0 ||
          en[w] !== 1'b0 || bsy[w] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: rdy=%b val=%b sel=%0d err=%b en=%b busy=%b required 1/0/0/0/0/0",
                 w, irdy[w], ov[w], sel[w], err[w], en[w], bsy[w]);
      end
    end
  endtask

  task automatic test_reset_mid_dwell;
    int seen;
    c_in[0] = 3'd5; r_in[0] = 3'd2; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1; iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++;
    if (en[0] !== 1'b1) begin
      n_fail++; $display("FAIL mid_dwell_setup: dmx_en=%b required 1", en[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (irdy[0] !== 1'b1 || ov[0] !== 1'b0 || sel[0] !== 2'd0 || err[0] !== 1'b0 ||
        en[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b val=%b sel=%0d err=%b en=%b busy=%b required 1/0/0/0/0/0",
               irdy[0], ov[0], sel[0], err[0], en[0], bsy[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (en[0] === 1'b1 || bsy[0] === 1'b1) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++; $display("FAIL post_reset_dwell: active cycles=%0d required 0", seen);
    end
    ordy[0] = 1'b0;
  endtask

  task automatic test_corners;
    txn(0, 5, 2, 0);
    txn(0, 0, 0, 0);
    txn(0, 7, 0, 0);
    txn(0, 0, 7, 0);
    txn(0, 7, 7, 0);
  endtask

  task automatic test_backpressure;
    txn(0, 3, 6, 10);
  endtask

  task automatic test_param;
    txn(1, 6, 1, 0);
    txn(1, 5, 5, 0);
    txn(1, 0, 5, 2);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++)
      txn(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
    for (int i = 0; i < 10; i++)
      txn(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
  endtask

  task automatic test_back_to_back;
    localparam int N = 6;
    int         acc[$];
    logic       e;
    logic [1:0] exp_s;
    logic       accepted;
    int         k, cyc, en_cnt;
    k = 0; cyc = 0; en_cnt = 0; exp_s = 2'd0;
    c_in[1] = 3'($urandom_range(0, 5)); r_in[1] = 3'($urandom_range(0, 5));
    iv[1] = 1'b1; ordy[1] = 1'b1;
    while (k < N && cyc < 200) begin
      accepted = irdy[1];
      if (accepted) begin
        acc.push_back(cyc);
        model(1, int'(c_in[1]), int'(r_in[1]), e, exp_s);
      end
      @(posedge clk); #1; cyc++;
      if (accepted) begin
        k++;
        c_in[1] = 3'($urandom_range(0, 5)); r_in[1] = 3'($urandom_range(0, 5));
      end
      if (en[1] === 1'b1) begin
        en_cnt++;
        n_chk++;
        if (sel[1] !== exp_s) begin
          n_fail++; $display("FAIL b2b_sel: sel=%0d required %0d", sel[1], exp_s);
        end
      end
    end
    iv[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (en[1] === 1'b1) begin
        en_cnt++;
        n_chk++;
        if (sel[1] !== exp_s) begin
          n_fail++; $display("FAIL b2b_sel_tail: sel=%0d required %0d", sel[1], exp_s);
        end
      end
    end
    n_chk++;
    if (k != N || en_cnt != N) begin
      n_fail++; $display("FAIL b2b_count: accepts=%0d en_cycles=%0d required %0d/%0d", k, en_cnt, N, N);
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_chk++;
      if (acc[i] - acc[i-1] != 4) begin
        n_fail++; $display("FAIL b2b_spacing: gap=%0d required 4", acc[i] - acc[i-1]);
      end
    end
    ordy[1] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      iv[w] = 1'b0; c_in[w] = 3'd0; r_in[w] = 3'd0; ordy[w] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_corners;
    test_backpressure;
    test_param;
    test_back_to_back;
    test_random;
    test_reset_mid_dwell;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
